// File: rtl/cod_bhl.sv
// cod_bhl: registered 3-bit-code to 14-segment (starburst) display encoder.
//
// Purpose:
//   Decodes the 3-bit code {A,B,C} (A = MSB) into the glyph for decimal 0-7
//   on one 14-segment digit. Every segment has its own combinational decode
//   function. All fourteen results are captured in a single output register,
//   so the pad lines change only on a clock edge and never show a mixed glyph.
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous active-high reset (blanks the digit)
//   A, B, C             in   code bits 2..0
//   a, b, c, d, e, f    out  outer ring segments (active-high)
//   g1, g2              out  middle bar, left / right halves
//   h, i, j             out  upper diagonals / upper centre vertical
//   k, l, m             out  lower diagonals / lower centre vertical
//
// Latency is one cycle. The register reloads on every clock. There is no
// enable and no handshake.

module cod_bhl (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g1,
    output logic g2,
    output logic h,
    output logic i,
    output logic j,
    output logic k,
    output logic l,
    output logic m
);

    // Per-segment lit-masks: bit n set means the segment is lit for code n.
    localparam logic [7:0] MASK_A  = 8'b1110_1101; // 0,2,3,5,6,7
    localparam logic [7:0] MASK_B  = 8'b1001_1111; // 0,1,2,3,4,7
    localparam logic [7:0] MASK_C  = 8'b1111_1011; // all but 2
    localparam logic [7:0] MASK_D  = 8'b0110_1101; // 0,2,3,5,6
    localparam logic [7:0] MASK_E  = 8'b0100_0101; // 0,2,6
    localparam logic [7:0] MASK_F  = 8'b0111_0001; // 0,4,5,6
    localparam logic [7:0] MASK_G1 = 8'b0111_0100; // 2,4,5,6
    localparam logic [7:0] MASK_G2 = 8'b0111_1100; // 2,3,4,5,6
    localparam logic [7:0] MASK_J  = 8'b0000_0011; // 0 (slash), 1 (flag)
    localparam logic [7:0] MASK_K  = 8'b0000_0001; // 0 (slash)

    function automatic logic dec_a(input logic [2:0] code);
        return MASK_A[code];
    endfunction

    function automatic logic dec_b(input logic [2:0] code);
        return MASK_B[code];
    endfunction

    function automatic logic dec_c(input logic [2:0] code);
        return MASK_C[code];
    endfunction

    function automatic logic dec_d(input logic [2:0] code);
        return MASK_D[code];
    endfunction

    function automatic logic dec_e(input logic [2:0] code);
        return MASK_E[code];
    endfunction

    function automatic logic dec_f(input logic [2:0] code);
        return MASK_F[code];
    endfunction

    function automatic logic dec_g1(input logic [2:0] code);
        return MASK_G1[code];
    endfunction

    function automatic logic dec_g2(input logic [2:0] code);
        return MASK_G2[code];
    endfunction

    function automatic logic dec_j(input logic [2:0] code);
        return MASK_J[code];
    endfunction

    function automatic logic dec_k(input logic [2:0] code);
        return MASK_K[code];
    endfunction

    // h, i, l, m are not part of any digit glyph. They are decoded as dark
    // for every code. The code argument is kept so that each segment has a
    // uniform decode interface.
    function automatic logic dec_dark(input logic [2:0] code);
        return (code == code) ? 1'b0 : 1'b0;
    endfunction

    logic [2:0]  code;
    logic [13:0] seg_d;   // bit order a,b,c,d,e,f,g1,g2,h,i,j,k,l,m (MSB first)
    logic [13:0] seg_q;

    assign code = {A, B, C};

    always_comb begin
        seg_d = '0;
        seg_d[13] = dec_a(code);
        seg_d[12] = dec_b(code);
        seg_d[11] = dec_c(code);
        seg_d[10] = dec_d(code);
        seg_d[9]  = dec_e(code);
        seg_d[8]  = dec_f(code);
        seg_d[7]  = dec_g1(code);
        seg_d[6]  = dec_g2(code);
        seg_d[5]  = dec_dark(code);   // h
        seg_d[4]  = dec_dark(code);   // i
        seg_d[3]  = dec_j(code);
        seg_d[2]  = dec_k(code);
        seg_d[1]  = dec_dark(code);   // l
        seg_d[0]  = dec_dark(code);   // m
    end

    // Only state in the block. Reset blanks the digit at once, without
    // waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign {a, b, c, d, e, f, g1, g2, h, i, j, k, l, m} = seg_q;

endmodule

// File: tb/tb_cod_bhl.sv
// Directed bench for cod_bhl. The expected glyphs come from the display
// table written out below as 14-bit constants in a,b,c,d,e,f,g1,g2,h,i,j,k,l,m
// order.

module tb_cod_bhl;

    logic clk;
    logic rst;
    logic A, B, C;
    logic a, b, c, d, e, f, g1, g2, h, i, j, k, l, m;

    int n_cmp;
    int n_bad;

    logic [13:0] glyph_tab [8];
    logic [13:0] seg_obs;

    cod_bhl dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .g1(g1), .g2(g2), .h(h), .i(i), .j(j), .k(k), .l(l), .m(m)
    );

    assign seg_obs = {a, b, c, d, e, f, g1, g2, h, i, j, k, l, m};

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // h,i,l,m are bits 5,4,1,0 of the observed word.
    task automatic check_unused(input string tag);
        check_eq(tag, {10'd0, seg_obs[5], seg_obs[4], seg_obs[1], seg_obs[0]}, 14'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_code(input int code);
        logic [2:0] v;
        v = code[2:0];
        {A, B, C} = v;
    endtask

    // Drive on the falling edge, then check #1 after the loading edge.
    task automatic apply_and_check(input int code, input string tag);
        @(negedge clk);
        set_code(code);
        @(posedge clk);
        #1;
        check_eq(tag, seg_obs, glyph_tab[code]);
        check_unused({tag, "_unused"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        glyph_tab[0] = 14'b11111100001100;
        glyph_tab[1] = 14'b01100000001000;
        glyph_tab[2] = 14'b11011011000000;
        glyph_tab[3] = 14'b11110001000000;
        glyph_tab[4] = 14'b01100111000000;
        glyph_tab[5] = 14'b10110111000000;
        glyph_tab[6] = 14'b10111111000000;
        glyph_tab[7] = 14'b11100000000000;

        // Reset with code 7 applied: outputs blank immediately and stay blank.
        rst = 1'b1;
        {A, B, C} = 3'b111;
        #1;
        check_eq("reset_immediate", seg_obs, 14'd0);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            check_eq("reset_hold", seg_obs, 14'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_release_pre_edge", seg_obs, 14'd0);
        @(posedge clk);
        #1;
        check_eq("reset_first_edge", seg_obs, 14'b11100000000000);

        // Exhaustive sweep, one code per cycle.
        for (int code = 0; code < 8; code++) begin
            apply_and_check(code, $sformatf("sweep_%0d", code));
        end

        // Latency/hold: code 4 right after an edge, then code 1 mid-cycle.
        // The output must keep glyph 7 (last sweep value) until the edge.
        set_code(4);
        #2;
        check_eq("hold_after_code4", seg_obs, glyph_tab[7]);
        @(negedge clk);
        set_code(1);
        #1;
        check_eq("hold_after_code1", seg_obs, glyph_tab[7]);
        @(posedge clk);
        #1;
        check_eq("hold_edge_loads_1", seg_obs, 14'b01100000001000);

        // Async reset mid-stream: raise rst between edges during a sweep.
        apply_and_check(2, "mid_pre_2");
        apply_and_check(3, "mid_pre_3");
        set_code(5);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_async_blank", seg_obs, 14'd0);
        @(posedge clk);
        #1;
        check_eq("mid_blank_hold", seg_obs, 14'd0);
        check_unused("mid_blank_unused");
        @(negedge clk);
        set_code(6);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_release_load_6", seg_obs, glyph_tab[6]);

        // Back-to-back alternation 0/7.
        for (int n = 0; n < 8; n++) begin
            apply_and_check((n % 2 == 0) ? 0 : 7, $sformatf("alt_%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cod_bhl.md
# cod_bhl

Registered 3-bit-code to 14-segment (alphanumeric starburst) display encoder. It takes a 3-bit binary code {A,B,C} and drives the fourteen segment lines of one display digit with the glyph for decimal 0–7. Each segment is produced by its own combinational per-segment decode function. All fourteen are captured in an output register so the display lines are glitch-free and change only on a clock edge. It sits between the code-generating logic and the display pad drivers.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  1  code bit 2 (MSB).
- B  input  1  code bit 1.
- C  input  1  code bit 0 (LSB).
- a  output  1  top horizontal segment.
- b  output  1  upper-right vertical.
- c  output  1  lower-right vertical.
- d  output  1  bottom horizontal.
- e  output  1  lower-left vertical.
- f  output  1  upper-left vertical.
- g1  output  1  middle horizontal, left half.
- g2  output  1  middle horizontal, right half.
- h  output  1  upper-left diagonal.
- i  output  1  upper centre vertical.
- j  output  1  upper-right diagonal.
- k  output  1  lower-left diagonal.
- l  output  1  lower centre vertical.
- m  output  1  lower-right diagonal.

## Operation
- Segments are active-high: 1 means lit.
- code = {A,B,C}, unsigned, range 0–7. Every code is valid, so there is no illegal-input case.
- Each segment has a separate combinational decode function of {A,B,C}. Only the output register holds state.
- Glyph table, bit order a,b,c,d,e,f,g1,g2,h,i,j,k,l,m:
  - 0 → 11111100001100 (ring plus j/k slash)
  - 1 → 01100000001000 (b, c, j flag)
  - 2 → 11011011000000
  - 3 → 11110001000000
  - 4 → 01100111000000
  - 5 → 10110111000000
  - 6 → 10111111000000
  - 7 → 11100000000000
- h, i, l and m are never lit by codes 0–7. They are still driven by explicit decode logic that holds them 0.

## Timing
- {A,B,C} are sampled on each clk rising edge. The corresponding glyph appears on the outputs after that edge: 1-cycle latency, throughput of 1 code per cycle.
- No handshake, no enable. The register reloads on every clock.
- Reset value: every output is 0, i.e. all segments dark (blank digit).
- Asserting rst blanks all outputs immediately, without waiting for a clock edge. This holds even mid-stream.
- While rst is high, outputs stay 0 regardless of clock or inputs.
- On the first rising edge after rst deasserts, the register loads the decode of the current {A,B,C}.
- Inputs changing between edges have no effect on the outputs until the next edge.
- Outputs never show an intermediate or mixed glyph.

## Test plan
- Reset: assert rst with A,B,C=1,1,1 and clk running. All 14 outputs are 0 immediately and remain 0 until the first edge after release. That edge yields 11100000000000.
- Exhaustive sweep: apply codes 0–7 in order, one per cycle. Each glyph above appears exactly one cycle after its code, e.g. code 2 → 11011011000000.
- Latency/hold: apply code 4 just after an edge, then change to code 1 mid-cycle.
  - Output stays at the previous glyph until the edge.
  - The edge then loads 01100000001000, from the value present at the edge.
- Async reset mid-stream: while sweeping codes, raise rst between clock edges. Outputs go to all-zero before the next edge.
- Unused segments: across all 8 codes and all reset states, h, i, l and m are always 0.
- Back-to-back alternation: alternate codes 0 and 7 every cycle. Outputs alternate 11111100001100 / 11100000000000 with no skipped or duplicated cycle.
